// File: rtl/dmac_pkg.sv
// -----------------------------------------------------------------------------
// dmac_pkg
// Shared definitions for the DMA controller AHB-Lite master port:
//   - AHB HTRANS / HSIZE / HBURST encodings used by this master
//   - FSM state enum of dmac_ahb_master
//   - command record {is_rd, addr, wdata} passed between capture, pending
//     slot and the active transfer register
// No ports (package).
// -----------------------------------------------------------------------------
package dmac_pkg;

   // Widths of the command record; the master's ADDR_W/DATA_W default to these.
   localparam int CMD_ADDR_W = 32;
   localparam int CMD_DATA_W = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   typedef struct packed {
      logic                  is_rd;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/dmac_ahb_master_if.sv
// -----------------------------------------------------------------------------
// dmac_ahb_master_if
// AHB-Lite bus bundle between the DMA master port and the fabric.
//   master modport: drives haddr, htrans, hwrite, hsize, hburst, hwdata;
//                   samples hrdata, hready, hresp
//   slave  modport: the mirror image
// -----------------------------------------------------------------------------
interface dmac_ahb_master_if
   import dmac_pkg::*;
#(
   parameter int ADDR_W = CMD_ADDR_W,
   parameter int DATA_W = CMD_DATA_W
);
   logic [ADDR_W-1:0] haddr;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [DATA_W-1:0] hwdata;
   logic [DATA_W-1:0] hrdata;
   logic              hready;
   logic              hresp;

   modport master (
      output haddr, htrans, hwrite, hsize, hburst, hwdata,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  haddr, htrans, hwrite, hsize, hburst, hwdata,
      output hrdata, hready, hresp
   );
endinterface

// File: rtl/dmac_cmd_slot.sv
// -----------------------------------------------------------------------------
// dmac_cmd_slot
// One-entry pending command buffer with a sticky loss flag.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : store load_cmd (accepted if empty, or if popped this cycle)
//   load_cmd   : command to store
//   pop        : consume the stored command
//   conflict   : a command was discarded upstream (rd+wr together)
//   full       : slot holds a command
//   cmd        : stored command
//   drop       : sticky, set when any command is lost; cleared only by rst
// -----------------------------------------------------------------------------
module dmac_cmd_slot
   import dmac_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  cmd_t load_cmd,
   input  logic pop,
   input  logic conflict,
   output logic full,
   output cmd_t cmd,
   output logic drop
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 1'b0;
         // NOTE: the payload is reset as well; it is a single register, and a
         // known value keeps the bus outputs deterministic after reset.
         cmd  <= '0;
         drop <= 1'b0;
      end else begin
         // A pop in the same cycle frees the entry for the incoming command.
         if (load && (!full || pop)) begin
            full <= 1'b1;
            cmd  <= load_cmd;
         end else if (pop) begin
            full <= 1'b0;
         end
         if ((load && full && !pop) || conflict)
            drop <= 1'b1;
      end
   end

endmodule

// File: rtl/dmac_ahb_master.sv
// -----------------------------------------------------------------------------
// dmac_ahb_master
// Single-channel AHB-Lite master port for the DMA controller. Each rd/wr pulse
// becomes one non-pipelined single-beat transfer; a command arriving while a
// transfer is busy waits in a one-entry pending slot.
//   clk, rst       : clock, asynchronous active-high reset
//   rd, wr         : one-cycle command pulses (rd wins if both; drop is set)
//   addr, wdata    : command address / write data, sampled with the pulse
//   rdata, rd_en   : read data and one-cycle read-complete strobe
//   hready_in      : one-cycle write-complete strobe
//   drop           : sticky, a command was lost
//   err            : one-cycle error strobe, coincident with completion
//   ahb            : AHB-Lite master modport (dmac_ahb_master_if)
// Optional feature: define DMAC_AHB_ERR_EN to honour ERROR responses (ERR
// state, err pulse, rdata forced to 0). Undefined: hresp ignored, err = 0.
// -----------------------------------------------------------------------------
module dmac_ahb_master
   import dmac_pkg::*;
#(
   parameter int ADDR_W = CMD_ADDR_W,
   parameter int DATA_W = CMD_DATA_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd,
   input  logic                 wr,
   input  logic [ADDR_W-1:0]    addr,
   input  logic [DATA_W-1:0]    wdata,
   output logic [DATA_W-1:0]    rdata,
   output logic                 rd_en,
   output logic                 hready_in,
   output logic                 drop,
   output logic                 err,
   dmac_ahb_master_if.master    ahb
);

   state_t state, state_nxt;
   cmd_t   cur, new_cmd, slot_cmd;
   logic   new_valid, slot_full, slot_pop, slot_load, load_cur;
   logic   done, done_err;

   assign new_valid = rd | wr;
   // A simultaneous rd+wr becomes a read; the write half is reported via drop.
   assign new_cmd   = '{is_rd: rd, addr: addr, wdata: wdata};

   dmac_cmd_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (slot_load),
      .load_cmd (new_cmd),
      .pop      (slot_pop),
      .conflict (rd & wr),
      .full     (slot_full),
      .cmd      (slot_cmd),
      .drop     (drop)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_nxt = state;
      slot_pop  = 1'b0;
      slot_load = 1'b0;
      load_cur  = 1'b0;
      done      = 1'b0;
      done_err  = 1'b0;
      // New commands go to the slot unless IDLE can take them directly; in
      // IDLE the slot has priority, so a new command replaces the popped entry.
      if (new_valid && (state != ST_IDLE || slot_full))
         slot_load = 1'b1;
      case (state)
         ST_IDLE: begin
            if (slot_full || new_valid) begin
               slot_pop  = slot_full;
               load_cur  = 1'b1;
               state_nxt = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (ahb.hready) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (ahb.hready) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
`ifdef DMAC_AHB_ERR_EN
            else if (ahb.hresp) begin
               // First cycle of a two-cycle ERROR response.
               state_nxt = ST_ERR;
            end
`endif
         end
         ST_ERR: begin
            if (ahb.hready) begin
               done      = 1'b1;
               done_err  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur       <= '0;
         rdata     <= '0;
         rd_en     <= 1'b0;
         hready_in <= 1'b0;
      end else begin
         if (load_cur) cur <= slot_full ? slot_cmd : new_cmd;
         rd_en     <= done &&  cur.is_rd;
         hready_in <= done && !cur.is_rd;
         if (done && cur.is_rd) rdata <= done_err ? '0 : ahb.hrdata;
      end
   end

`ifdef DMAC_AHB_ERR_EN
   logic err_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= done_err;
   end
   assign err = err_q;
`else
   logic unused_hresp;
   assign unused_hresp = ahb.hresp;
   assign err          = 1'b0;
`endif

   // Bus outputs decode from registers only, so reset idles the bus at once.
   assign ahb.htrans = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign ahb.haddr  = cur.addr;
   assign ahb.hwrite = (state == ST_ADDR) && !cur.is_rd;
   assign ahb.hwdata = cur.is_rd ? '0 : cur.wdata;
   assign ahb.hsize  = HSIZE_WORD;
   assign ahb.hburst = HBURST_SINGLE;

endmodule

// File: tb/tb_dmac_ahb_master.sv
// -----------------------------------------------------------------------------
// tb_dmac_ahb_master
// Self-checking bench for dmac_ahb_master. Expected bus address phases and
// expected completions are queued when commands are driven; negedge monitors
// pop and compare them. Directed sequences check cycle timing directly.
// Works with or without DMAC_AHB_ERR_EN.
// -----------------------------------------------------------------------------
module tb_dmac_ahb_master;
   import dmac_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic        write;
   } bus_exp_t;

   typedef struct {
      logic        is_rd;
      logic [31:0] data;
      logic        err;
   } done_exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd = 1'b0, wr = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata;
   logic        rd_en, hready_in, drop, err;

   int n_cmp = 0;
   int n_bad = 0;

   bus_exp_t  bus_q[$];
   done_exp_t done_q[$];

   dmac_ahb_master_if #(.ADDR_W(32), .DATA_W(32)) ahb ();

   dmac_ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .rd        (rd),
      .wr        (wr),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .rd_en     (rd_en),
      .hready_in (hready_in),
      .drop      (drop),
      .err       (err),
      .ahb       (ahb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      rd = r; wr = w; addr = a; wdata = d;
      tick();
      rd = 1'b0; wr = 1'b0;
   endtask

   task automatic push_bus(input logic [31:0] a, input logic w);
      bus_exp_t e;
      e.addr = a; e.write = w;
      bus_q.push_back(e);
   endtask

   task automatic push_done(input logic r, input logic [31:0] d, input logic e_err);
      done_exp_t e;
      e.is_rd = r; e.data = d; e.err = e_err;
      done_q.push_back(e);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Address-phase monitor: every accepted NONSEQ must match the next expected transfer.
   always @(negedge clk) begin
      if (!rst && ahb.htrans == HTRANS_NONSEQ && ahb.hready) begin
         if (bus_q.size() == 0) begin
            check("spurious_nonseq", 1, 0);
         end else begin
            bus_exp_t e;
            e = bus_q.pop_front();
            check("bus_haddr", ahb.haddr, e.addr);
            check("bus_hwrite", ahb.hwrite, e.write);
         end
      end
   end

   // Completion monitor: one pulse per accepted command, in order.
   always @(negedge clk) begin
      if (!rst && (rd_en || hready_in)) begin
         if (done_q.size() == 0) begin
            check("spurious_done", 1, 0);
         end else begin
            done_exp_t e;
            e = done_q.pop_front();
            check("done_kind_rd", rd_en, e.is_rd);
            check("done_kind_wr", hready_in, !e.is_rd);
            if (e.is_rd) check("done_rdata", rdata, e.data);
            check("done_err", err, e.err);
         end
      end
   end

   initial begin
      logic [31:0] err_data;
      logic        err_flag;

      ahb.hready = 1'b1;
      ahb.hresp  = 1'b0;
      ahb.hrdata = '0;

      // Reset state
      tick();
      tick();
      check("rst_htrans", ahb.htrans, HTRANS_IDLE);
      check("rst_hsize", ahb.hsize, 3'b010);
      check("rst_hburst", ahb.hburst, 3'b000);
      check("rst_haddr", ahb.haddr, 0);
      check("rst_hwrite", ahb.hwrite, 0);
      check("rst_outs", {rd_en, hready_in, drop, err}, 4'b0000);
      check("rst_rdata", rdata, 0);
      rst = 1'b0;
      tick();

      // Single read
      ahb.hrdata = 32'hDEAD_BEEF;
      push_bus(32'h1000_0040, 1'b0);
      push_done(1'b1, 32'hDEAD_BEEF, 1'b0);
      send(1'b1, 1'b0, 32'h1000_0040, 32'h0);             // now N+1
      check("rd_n1_nonseq", ahb.htrans, HTRANS_NONSEQ);
      check("rd_n1_hwrite", ahb.hwrite, 0);
      tick();                                             // N+2
      check("rd_n2_idle", ahb.htrans, HTRANS_IDLE);
      check("rd_n2_no_done", rd_en, 0);
      tick();                                             // N+3
      check("rd_n3_rd_en", rd_en, 1);
      check("rd_n3_rdata", rdata, 32'hDEAD_BEEF);
      tick();
      check("rd_pulse_one_cycle", rd_en, 0);
      check("rd_rdata_held", rdata, 32'hDEAD_BEEF);

      // Write with two data-phase wait states
      push_bus(32'h2000_0000, 1'b1);
      push_done(1'b0, 32'h0, 1'b0);
      send(1'b0, 1'b1, 32'h2000_0000, 32'h1234_5678);     // N+1
      check("wr_n1_nonseq", ahb.htrans, HTRANS_NONSEQ);
      tick();                                             // N+2
      ahb.hready = 1'b0;
      check("wr_hwdata_0", ahb.hwdata, 32'h1234_5678);
      tick();                                             // N+3
      check("wr_hwdata_1", ahb.hwdata, 32'h1234_5678);
      check("wr_htrans_wait", ahb.htrans, HTRANS_IDLE);
      tick();                                             // N+4
      ahb.hready = 1'b1;
      check("wr_hwdata_2", ahb.hwdata, 32'h1234_5678);
      check("wr_n4_no_done", hready_in, 0);
      tick();                                             // N+5
      check("wr_n5_hready_in", hready_in, 1);
      tick();

      // Pending slot and overflow
      ahb.hrdata = 32'h0BAD_F00D;
      push_bus(32'h3000_0010, 1'b0);
      push_done(1'b1, 32'h0BAD_F00D, 1'b0);
      send(1'b1, 1'b0, 32'h3000_0010, 32'h0);             // N+1
      tick();                                             // N+2 data phase
      ahb.hready = 1'b0;
      push_bus(32'h3000_0020, 1'b1);
      push_done(1'b0, 32'h0, 1'b0);
      send(1'b0, 1'b1, 32'h3000_0020, 32'hA5A5_0001);     // queued; now N+3
      check("pend_no_drop", drop, 0);
      send(1'b1, 1'b0, 32'h3000_0030, 32'h0);             // slot full: lost; now N+4
      check("ovf_drop", drop, 1);
      ahb.hready = 1'b1;
      tick();                                             // N+5
      check("pend_rd_en", rd_en, 1);
      check("pend_idle_on_done", ahb.htrans, HTRANS_IDLE);
      tick();                                             // N+6
      check("pend_nonseq", ahb.htrans, HTRANS_NONSEQ);
      check("pend_haddr", ahb.haddr, 32'h3000_0020);
      tick();                                             // N+7
      check("pend_hwdata", ahb.hwdata, 32'hA5A5_0001);
      tick();                                             // N+8
      check("pend_hready_in", hready_in, 1);
      tick();
      tick();
      check("pend_drained", done_q.size(), 0);

      // Simultaneous rd+wr: read wins, write lost
      apply_reset();
      check("sim_drop_clear", drop, 0);
      ahb.hrdata = 32'h5555_AAAA;
      push_bus(32'h4000_0000, 1'b0);
      push_done(1'b1, 32'h5555_AAAA, 1'b0);
      send(1'b1, 1'b1, 32'h4000_0000, 32'hFFFF_FFFF);     // N+1
      check("sim_hwrite", ahb.hwrite, 0);
      check("sim_nonseq", ahb.htrans, HTRANS_NONSEQ);
      tick();
      tick();                                             // N+3
      check("sim_rd_en", rd_en, 1);
      check("sim_drop", drop, 1);
      tick();

      // Two-cycle ERROR response on a read
`ifdef DMAC_AHB_ERR_EN
      err_data = 32'h0;
      err_flag = 1'b1;
`else
      err_data = 32'hCAFE_F00D;
      err_flag = 1'b0;
`endif
      ahb.hrdata = 32'hCAFE_F00D;
      push_bus(32'h5000_0004, 1'b0);
      push_done(1'b1, err_data, err_flag);
      send(1'b1, 1'b0, 32'h5000_0004, 32'h0);             // N+1
      tick();                                             // N+2
      ahb.hready = 1'b0;
      ahb.hresp  = 1'b1;
      tick();                                             // N+3
      ahb.hready = 1'b1;
      check("err_no_early_done", rd_en, 0);
      tick();                                             // N+4
      ahb.hresp = 1'b0;
      check("err_rd_en", rd_en, 1);
      check("err_flag", err, err_flag);
      check("err_rdata", rdata, err_data);
      tick();
      check("err_pulse_one_cycle", err, 0);

      // Reset during the address phase with a command pending
      apply_reset();
      ahb.hready = 1'b0;
      send(1'b1, 1'b0, 32'h6000_0000, 32'h0);             // N+1 address held
      send(1'b0, 1'b1, 32'h6000_0008, 32'h7777_7777);     // pending; now N+2
      check("rst_mid_pre", ahb.htrans, HTRANS_NONSEQ);
      rst = 1'b1;
      #1;
      check("rst_mid_async_idle", ahb.htrans, HTRANS_IDLE);
      tick();
      rst = 1'b0;
      ahb.hready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_slot_empty", ahb.htrans, HTRANS_IDLE);
         check("rst_no_done", {rd_en, hready_in}, 2'b00);
      end
      check("rst_drop_clear", drop, 0);

      // Recovery write after reset
      push_bus(32'h7000_0000, 1'b1);
      push_done(1'b0, 32'h0, 1'b0);
      send(1'b0, 1'b1, 32'h7000_0000, 32'h0F0F_0F0F);

      // Bounded drain of outstanding expectations
      for (int i = 0; i < 20 && (done_q.size() != 0 || bus_q.size() != 0); i++)
         tick();
      tick();
      check("final_done_q_empty", done_q.size(), 0);
      check("final_bus_q_empty", bus_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmac_ahb_master.md
# dmac_ahb_master

Single-channel AHB-Lite master port for the DMA controller. It sits directly downstream of the DMA channel controller. It accepts the controller's one-cycle `rd`/`wr` command pulses with `addr`/`wdata`, and runs a non-pipelined single-beat AHB-Lite transfer for each. It returns `rdata` with an `rd_en` strobe for reads and an `hready_in` strobe for writes. A one-entry pending slot absorbs a command that arrives while a transfer is in flight.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `hsize` is fixed to word
- `clk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `rd` in 1: read command pulse, one cycle
- `wr` in 1: write command pulse, one cycle
- `addr` in ADDR_W: command address, sampled with `rd`/`wr`
- `wdata` in DATA_W: write data, sampled with `wr`
- `rdata` out DATA_W: read data, valid while `rd_en`=1, then held
- `rd_en` out 1: read-complete pulse, one cycle
- `hready_in` out 1: write-complete pulse, one cycle
- `haddr` out ADDR_W: AHB address
- `htrans` out 2: AHB transfer type, IDLE=2'b00, NONSEQ=2'b10
- `hwrite` out 1: AHB direction
- `hsize` out 3: constant 3'b010
- `hburst` out 3: constant 3'b000 (SINGLE)
- `hwdata` out DATA_W: AHB write data
- `hrdata` in DATA_W: AHB read data
- `hready` in 1: AHB ready
- `hresp` in 1: AHB response, 1=ERROR
- `drop` out 1: sticky flag; a command was lost
- `err` out 1: error pulse, one cycle (macro-dependent)

## Operation
- **Reset values:** all outputs 0; `hsize`=3'b010; state IDLE; pending slot empty.
- **Command capture:** `{rd, wr, addr, wdata}` is captured on the cycle the pulse is seen.
  - If `rd` and `wr` are high in the same cycle, the read is captured and the write is discarded; `drop` is set.
- **FSM states:** IDLE, ADDR, DATA, ERR.
- **IDLE:**
  - A captured command or an occupied pending slot moves to ADDR.
  - The pending slot has priority over a new command. A new command arriving in that same cycle goes into the slot.
- **ADDR:**
  - Drives `htrans`=NONSEQ, `haddr`, `hwrite`.
  - `hready`=1 moves to DATA; otherwise the address is held stable.
- **DATA:**
  - Drives `htrans`=IDLE; `hwdata` = captured write data for the whole phase.
  - `hready`=1 completes the transfer:
    - read: `rdata` <= `hrdata` and `rd_en` pulses;
    - write: `hready_in` pulses.
  - After completion the FSM returns to IDLE.
- **Pending slot:**
  - A command arriving while state is not IDLE is stored in the slot.
  - A command arriving while the slot is occupied is discarded and `drop` is set.
  - `drop` clears only on reset.
- **Completion:** exactly one completion pulse per accepted command, including errored ones.

## Timing
- With `hready` held at 1:
  - command pulse in cycle N;
  - NONSEQ on the bus in N+1;
  - data phase in N+2;
  - `rd_en`/`hready_in` high in N+3 (registered).
- Back-to-back: a pending command issues NONSEQ in the cycle after the completion pulse.
- `hready`=0 in ADDR or DATA adds one cycle per low cycle. Outputs are held stable.
- Reset mid-transfer: the bus returns to IDLE immediately (asynchronously). No completion pulse is produced.

## Configuration
- **`DMAC_AHB_ERR_EN` defined:**
  - In DATA, `hresp`=1 with `hready`=0 moves to ERR.
  - ERR waits for `hready`=1, then pulses `err` together with the normal completion pulse, and forces `rdata`=0 for reads.
- **Undefined:**
  - `hresp` is ignored and ERR is unreachable.
  - `err` is tied to 0.
  - Completion depends only on `hready`.

## Structure
- **Package `dmac_pkg`** holds:
  - the HTRANS_IDLE and HTRANS_NONSEQ constants;
  - HSIZE_WORD and HBURST_SINGLE;
  - the FSM state enum;
  - a command struct `{is_rd, addr, wdata}`.
- **Sub-module `dmac_cmd_slot`:** the one-entry pending buffer, with load/pop/full and the `drop` flag.

## Test plan
- **Single read:** `hready`=1, `rd` pulse at `addr`=0x1000_0040, `hrdata`=0xDEAD_BEEF.
  - NONSEQ at N+1 with `hwrite`=0.
  - `rd_en`=1 with `rdata`=0xDEAD_BEEF at N+3.
- **Write with 2 wait states:** `wr` at 0x2000_0000 with `wdata`=0x1234_5678, `hready` low for 2 data-phase cycles.
  - `hwdata` is stable throughout.
  - `hready_in` pulses at N+5.
- **Pending and overflow:**
  - `wr` while a read is in DATA: queued, issues after `rd_en`.
  - A third command while the slot is full: dropped, `drop`=1.
- **Simultaneous commands:** `rd`+`wr` in the same cycle → only a read on the bus, `drop`=1.
- **Error (`DMAC_AHB_ERR_EN`):** two-cycle ERROR response on a read → `err` and `rd_en` pulse together with `rdata`=0. Without the macro, the same stimulus returns `hrdata`.
- **Reset mid-transfer:** `rst` asserted in ADDR → `htrans`=IDLE in the same cycle; no completion pulse; slot empty after release.
